// File: rtl/action_arbiter_if.sv
// Button/command bundle between the user-input side and action_arbiter.
// master drives the raw inputs and observes commands; slave is the arbiter itself.
interface action_arbiter_if;
    logic       botonSleep;
    logic       botonAwake;
    logic       botonFeed;
    logic       botonPlay;
    logic       giro;
    logic       botonTest;
    logic [3:0] pulseTest;
    logic       dead;
    logic       cmd_sleep;
    logic       cmd_awake;
    logic       cmd_feed;
    logic       cmd_play;
    logic       cmd_giro;
    logic       cmd_tick;
    logic [5:0] pending;
    logic       busy;

    modport master (
        output botonSleep, botonAwake, botonFeed, botonPlay, giro, botonTest, pulseTest, dead,
        input  cmd_sleep, cmd_awake, cmd_feed, cmd_play, cmd_giro, cmd_tick, pending, busy
    );

    modport slave (
        input  botonSleep, botonAwake, botonFeed, botonPlay, giro, botonTest, pulseTest, dead,
        output cmd_sleep, cmd_awake, cmd_feed, cmd_play, cmd_giro, cmd_tick, pending, busy
    );
endinterface

// File: rtl/action_arbiter.sv
// Button request arbiter: sync + edge detect, pending latch, one grant per cooldown, test tick bursts.
// Optional macro ROUND_ROBIN_EN rotates feed/play/giro instead of fixed priority.
module action_arbiter #(
    parameter int unsigned COOLDOWN  = 4,
    parameter int unsigned BURST_GAP = 2
) (
    input  logic           clk,
    input  logic           rst,
    action_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_COOL  = 2'd2;
    localparam logic [1:0] S_BURST = 2'd3;
    localparam logic [7:0] CD_LOAD  = 8'(COOLDOWN - 1);
    localparam logic [3:0] GAP_LOAD = 4'(BURST_GAP);

    // bit order everywhere: {test,giro,play,feed,sleep,awake}
    logic [5:0] raw_s, sync1_q, sync2_q, prev_q, rise_q;
    logic [1:0] state_q, state_d;
    logic [5:0] pending_q, pending_d, eligible_s, cmd_q, cmd_d;
    logic [4:0] user_gnt_s;
    logic [3:0] burst_cnt_q, burst_cnt_d, gap_q, gap_d;
    logic [7:0] cd_q, cd_d;
    logic       busy_q, test_take_s;

    assign raw_s = {bus.botonTest, bus.giro, bus.botonPlay, bus.botonFeed, bus.botonSleep, bus.botonAwake};

`ifdef ROUND_ROBIN_EN
    logic [1:0] rr_q;

    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] g;
        g = 3'b000;
        case (ptr)
            2'd1: begin
                if (req[1]) g = 3'b010; else if (req[2]) g = 3'b100; else if (req[0]) g = 3'b001; else g = 3'b000;
            end
            2'd2: begin
                if (req[2]) g = 3'b100; else if (req[0]) g = 3'b001; else if (req[1]) g = 3'b010; else g = 3'b000;
            end
            default: begin
                if (req[0]) g = 3'b001; else if (req[1]) g = 3'b010; else if (req[2]) g = 3'b100; else g = 3'b000;
            end
        endcase
        return g;
    endfunction

    // Round-robin pointer moves just past each granted feed/play/giro
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 2'd0;
        end else if (state_q == S_IDLE && !eligible_s[5] && user_gnt_s[4:2] != 3'b000) begin
            rr_q <= user_gnt_s[2] ? 2'd1 : (user_gnt_s[3] ? 2'd2 : 2'd0);
        end else begin
            rr_q <= rr_q;
        end
    end
`endif

    // Requests the arbiter may act on; a dead pet only accepts test
    always_comb begin
        if (bus.dead) eligible_s = {pending_q[5], 5'b00000};
        else          eligible_s = pending_q;
    end

    // User winner: awake > sleep, then feed/play/giro
    always_comb begin
        user_gnt_s = 5'b00000;
        if (eligible_s[0])      user_gnt_s[0] = 1'b1;
        else if (eligible_s[1]) user_gnt_s[1] = 1'b1;
`ifdef ROUND_ROBIN_EN
        else                    user_gnt_s[4:2] = rr_pick(eligible_s[4:2], rr_q);
`else
        else if (eligible_s[2]) user_gnt_s[2] = 1'b1;
        else if (eligible_s[3]) user_gnt_s[3] = 1'b1;
        else if (eligible_s[4]) user_gnt_s[4] = 1'b1;
        else                    user_gnt_s = 5'b00000;
`endif
    end

    // A new test press is only taken outside a burst, when not already queued, with a nonzero length
    assign test_take_s = rise_q[5] && (state_q != S_BURST) && !pending_q[5] && (bus.pulseTest != 4'd0);

    // Next-state, command, counter and pending-request logic
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        burst_cnt_d = burst_cnt_q;
        gap_d       = gap_q;
        cd_d        = cd_q;
        cmd_d       = 6'b000000;
        case (state_q)
            S_IDLE: begin
                if (eligible_s[5]) begin
                    state_d      = S_BURST;
                    pending_d[5] = 1'b0;
                    cmd_d[5]     = 1'b1;
                    burst_cnt_d  = burst_cnt_q - 4'd1;
                    gap_d        = GAP_LOAD;
                end else if (user_gnt_s != 5'b00000) begin
                    state_d      = S_GRANT;
                    cmd_d[4:0]   = user_gnt_s;
                    pending_d    = pending_q & ~{1'b0, user_gnt_s};
                    if (user_gnt_s[0]) pending_d[1] = 1'b0;
                    else               pending_d[1] = pending_d[1];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                state_d = S_COOL;
                cd_d    = CD_LOAD;
            end
            S_COOL: begin
                if (cd_q == 8'd0) state_d = S_IDLE;
                else              cd_d    = cd_q - 8'd1;
            end
            S_BURST: begin
                if (cmd_q[5] && burst_cnt_q == 4'd0) begin
                    state_d = S_COOL;
                    cd_d    = CD_LOAD;
                end else if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else begin
                    cmd_d[5]    = 1'b1;
                    burst_cnt_d = burst_cnt_q - 4'd1;
                    gap_d       = GAP_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // new edges applied after grant-clear so a same-edge set wins
        if (bus.dead) pending_d[4:0] = 5'b00000;
        else          pending_d[4:0] = pending_d[4:0] | rise_q[4:0];
        if (test_take_s) begin
            pending_d[5] = 1'b1;
            burst_cnt_d  = bus.pulseTest;
        end else begin
            burst_cnt_d  = burst_cnt_d;
        end
    end

    // Synchronizers, edge detect and arbiter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 6'b000000;
            sync2_q     <= 6'b000000;
            prev_q      <= 6'b000000;
            rise_q      <= 6'b000000;
            state_q     <= S_IDLE;
            pending_q   <= 6'b000000;
            burst_cnt_q <= 4'd0;
            gap_q       <= 4'd0;
            cd_q        <= 8'd0;
            cmd_q       <= 6'b000000;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= raw_s;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            rise_q      <= sync2_q & ~prev_q;
            state_q     <= state_d;
            pending_q   <= pending_d;
            burst_cnt_q <= burst_cnt_d;
            gap_q       <= gap_d;
            cd_q        <= cd_d;
            cmd_q       <= cmd_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign bus.cmd_awake = cmd_q[0];
    assign bus.cmd_sleep = cmd_q[1];
    assign bus.cmd_feed  = cmd_q[2];
    assign bus.cmd_play  = cmd_q[3];
    assign bus.cmd_giro  = cmd_q[4];
    assign bus.cmd_tick  = cmd_q[5];
    assign bus.pending   = pending_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_action_arbiter.sv
// Directed bench for action_arbiter: table of single-press scenarios plus burst/dead/reset sequences.
module tb_action_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;

    typedef struct {
        int         cyc;
        logic [5:0] v;
    } ev_t;

    typedef struct {
        string      name;
        logic [5:0] press;
        logic [3:0] ptest;
        logic [5:0] first;
        int         lat;
        int         npulse;
        int         gap;
        logic [5:0] ormask;
        int         busy;
    } vec_t;

    ev_t  evq[$];
    int   busy_cnt;
    vec_t tbl[8];

    action_arbiter_if bus();

    action_arbiter #(.COOLDOWN(4), .BURST_GAP(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] cmdv();
        return {bus.cmd_tick, bus.cmd_giro, bus.cmd_play, bus.cmd_feed, bus.cmd_sleep, bus.cmd_awake};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic step();
        logic [5:0] v;
        @(posedge clk);
        #1;
        cyc++;
        v = cmdv();
        chk("onehot", int'($countones(v) <= 1), 1);
        if (v != 6'b000000) evq.push_back('{cyc, v});
        if (bus.busy) busy_cnt++;
    endtask

    task automatic press(input logic [5:0] b, input logic [3:0] pt);
        {bus.botonTest, bus.giro, bus.botonPlay, bus.botonFeed, bus.botonSleep, bus.botonAwake} = b;
        bus.pulseTest = pt;
    endtask

    task automatic release_btn();
        {bus.botonTest, bus.giro, bus.botonPlay, bus.botonFeed, bus.botonSleep, bus.botonAwake} = 6'b000000;
    endtask

    task automatic clear_mon();
        evq.delete();
        busy_cnt = 0;
    endtask

    function automatic int count_bit(input int b);
        int n = 0;
        foreach (evq[j]) if (evq[j].v[b]) n++;
        return n;
    endfunction

    function automatic int nth_cyc(input int b, input int nth);
        int n = 0;
        foreach (evq[j]) begin
            if (evq[j].v[b]) begin
                if (n == nth) return evq[j].cyc;
                n++;
            end
        end
        return -1;
    endfunction

    function automatic vec_t mk(input string nm, input logic [5:0] p, input logic [3:0] pt, input logic [5:0] f,
                                input int l, input int n, input int g, input logic [5:0] om, input int bz);
        vec_t r;
        r.name = nm; r.press = p; r.ptest = pt; r.first = f; r.lat = l;
        r.npulse = n; r.gap = g; r.ormask = om; r.busy = bz;
        return r;
    endfunction

    initial begin
        int t0;
        logic [5:0] orm;
        bus.dead = 1'b0;
        press(6'b000000, 4'd0);
        clear_mon();

        tbl[0] = mk("feed",          6'b000100, 4'd0, 6'b000100,  5, 1, 0, 6'b000100,  5);
        tbl[1] = mk("sleep_awake",   6'b000011, 4'd0, 6'b000001,  5, 1, 0, 6'b000001,  5);
        tbl[2] = mk("feed_play_giro",6'b011100, 4'd0, 6'b000100,  5, 3, 6, 6'b011100, 15);
        tbl[3] = mk("test5",         6'b100000, 4'd5, 6'b100000,  5, 5, 3, 6'b100000, 17);
        tbl[4] = mk("test0",         6'b100000, 4'd0, 6'b000000, -1, 0, 0, 6'b000000,  0);
        tbl[5] = mk("awake",         6'b000001, 4'd0, 6'b000001,  5, 1, 0, 6'b000001,  5);
        tbl[6] = mk("test1",         6'b100000, 4'd1, 6'b100000,  5, 1, 0, 6'b100000,  5);
        tbl[7] = mk("giro_awake",    6'b010001, 4'd0, 6'b000001,  5, 2, 6, 6'b010001, 10);

        // reset state
        repeat (3) step();
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_cmd", int'(cmdv()), 0);
        #1 rst = 1'b0;
        repeat (5) step();

        foreach (tbl[i]) begin
            clear_mon();
            t0 = cyc;
            press(tbl[i].press, tbl[i].ptest);
            step(); step();
            release_btn();
            repeat (58) step();
            orm = 6'b000000;
            foreach (evq[j]) orm |= evq[j].v;
            chk({tbl[i].name, "_npulse"}, evq.size(), tbl[i].npulse);
            chk({tbl[i].name, "_first"}, (evq.size() > 0) ? int'(evq[0].v) : 0, int'(tbl[i].first));
            chk({tbl[i].name, "_lat"}, (evq.size() > 0) ? evq[0].cyc - t0 : -1, tbl[i].lat);
            chk({tbl[i].name, "_ormask"}, int'(orm), int'(tbl[i].ormask));
            chk({tbl[i].name, "_busy"}, busy_cnt, tbl[i].busy);
            for (int j = 1; j < evq.size(); j++)
                chk({tbl[i].name, "_gap"}, evq[j].cyc - evq[j-1].cyc, tbl[i].gap);
            chk({tbl[i].name, "_pend_end"}, int'(bus.pending), 0);
        end

        // feed and a second test press during a burst
        clear_mon();
        t0 = cyc;
        press(6'b100000, 4'd5);
        step(); step();
        release_btn();
        repeat (4) step();
        press(6'b100100, 4'd3);
        step(); step();
        release_btn();
        repeat (4) step();
        chk("burst_feed_pend", int'(bus.pending[2]), 1);
        chk("burst_test_ignored", int'(bus.pending[5]), 0);
        repeat (30) step();
        chk("burst_ticks", count_bit(5), 5);
        chk("burst_last_tick", nth_cyc(5, 4) - t0, 17);
        chk("burst_feed_cnt", count_bit(2), 1);
        chk("burst_feed_cyc", nth_cyc(2, 0) - t0, 23);

        // dead clears pending user requests while test still works
        clear_mon();
        t0 = cyc;
        press(6'b100000, 4'd5);
        step(); step();
        release_btn();
        repeat (4) step();
        press(6'b001000, 4'd5);
        step(); step();
        release_btn();
        repeat (4) step();
        chk("dead_play_pend", int'(bus.pending[3]), 1);
        bus.dead = 1'b1;
        step();
        chk("dead_play_clr", int'(bus.pending[3]), 0);
        repeat (30) step();
        chk("dead_ticks", count_bit(5), 5);
        chk("dead_no_play", count_bit(3), 0);
        clear_mon();
        press(6'b100000, 4'd2);
        step(); step();
        release_btn();
        repeat (25) step();
        chk("dead_test_ticks", count_bit(5), 2);
        chk("dead_test_gap", nth_cyc(5, 1) - nth_cyc(5, 0), 3);
        bus.dead = 1'b0;
        repeat (5) step();

        // reset in the middle of a burst
        clear_mon();
        t0 = cyc;
        press(6'b100000, 4'd5);
        step(); step();
        release_btn();
        repeat (6) step();
        chk("abort_tick2", int'(bus.cmd_tick), 1);
        chk("abort_ticks_before", count_bit(5), 2);
        rst = 1'b1;
        #1;
        chk("abort_cmd", int'(cmdv()), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_pending", int'(bus.pending), 0);
        step(); step();
        rst = 1'b0;
        clear_mon();
        repeat (30) step();
        chk("abort_no_ticks", evq.size(), 0);
        chk("abort_idle_busy", busy_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
